// File: rtl/sram22_param_model.sv
// ---------------------------------------------------------------------------
// sram22_param_model
//
// Parametrised single-port SRAM behavioural model used by the BIST generator
// and the SRAM wrappers. Data width, depth and write-mask granularity are
// parameters. It also provides a chip enable, an optional output register
// stage and a write-through option. After reset, a hardware clear engine
// writes CLEAR_VAL into every word so that the array starts in a known state.
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | clear engine writes CLEAR_VAL to mem[cnt]; accesses ignored
//   ST_READY | normal operation; accesses accepted when en=1
//
// Ports:
//   clk        in   1            rising-edge clock
//   rstb       in   1            asynchronous active-low reset
//   en         in   1            chip enable
//   we         in   1            1 = write, 0 = read (qualified by en)
//   wmask      in   WMASK_WIDTH  per-lane write enable
//   addr       in   ADDR_WIDTH   word address
//   din        in   DATA_WIDTH   write data
//   dout       out  DATA_WIDTH   read / write-through data
//   dout_valid out  1            dout was updated by an access this cycle
//   busy       out  1            clear engine active
// ---------------------------------------------------------------------------
module sram22_param_model #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    WMASK_WIDTH = 4,
    parameter int                    WRITE_MODE  = 0,
    parameter int                    OUT_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL   = '0
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   en,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   busy
);

    localparam int                    RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int                    LANE_W    = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    generate
        if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_width
            $error("sram22_param_model: DATA_WIDTH must be a multiple of WMASK_WIDTH");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;

    logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];

    logic                    acc_ok;
    logic                    rd_acc;
    logic                    wr_acc;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Result of the access in the current cycle, before any output staging.
    logic                    res_load;
    logic [DATA_WIDTH-1:0]   res_data;

    // ------------------------------------------------------------------
    // Clear engine / FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Access decode and lane merge
    // ------------------------------------------------------------------
    always_comb begin
        acc_ok = (state_q == ST_READY) && en;
        rd_acc = acc_ok && !we;
        wr_acc = acc_ok && we;
    end

    always_comb begin
        old_word    = mem_q[addr];
        merged_word = old_word;
        for (int k = 0; k < WMASK_WIDTH; k++) begin
            if (wmask[k]) begin
                merged_word[k*LANE_W +: LANE_W] = din[k*LANE_W +: LANE_W];
            end
        end
    end

    // The clear engine owns the write port while in ST_CLEAR; a write with an
    // all-zero mask rewrites the old word, which keeps the port logic uniform.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = merged_word;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = CLEAR_VAL;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // A write only produces output data in write-through mode.
    always_comb begin
        res_load = rd_acc || (wr_acc && (WRITE_MODE != 0));
        res_data = we ? merged_word : old_word;
    end

    // ------------------------------------------------------------------
    // Output staging
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
            logic                  s1_valid_q, s1_valid_d;

            always_comb begin
                s1_valid_d   = res_load;
                s1_data_d    = res_load ? res_data : s1_data_q;
                dout_valid_d = s1_valid_q;
                dout_d       = s1_valid_q ? s1_data_q : dout_q;
            end

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    s1_data_q  <= '0;
                    s1_valid_q <= 1'b0;
                end else begin
                    s1_data_q  <= s1_data_d;
                    s1_valid_q <= s1_valid_d;
                end
            end
        end else begin : g_no_out_reg
            always_comb begin
                dout_valid_d = res_load;
                dout_d       = res_load ? res_data : dout_q;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sram22_param_model.sv
// ---------------------------------------------------------------------------
// Testbench for sram22_param_model. Three instances share one stimulus:
//   u_base : WRITE_MODE=0, OUT_REG=0
//   u_wt   : WRITE_MODE=1, OUT_REG=0
//   u_pipe : WRITE_MODE=0, OUT_REG=1
// All use CLEAR_VAL=32'hA5A5A5A5. A word-level model of the array pushes the
// expected output words into one queue per instance as stimulus is driven.
// ---------------------------------------------------------------------------
module tb_sram22_param_model;

    localparam logic [31:0] CV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  wmask = 4'h0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] din = 32'h0;

    logic [31:0] dout_b, dout_w, dout_p;
    logic        dv_b, dv_w, dv_p;
    logic        busy_b, busy_w, busy_p;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [256];
    logic [31:0] q_b [$];
    logic [31:0] q_w [$];
    logic [31:0] q_p [$];
    logic [31:0] last_b = 32'h0;
    logic [31:0] last_w = 32'h0;
    logic [31:0] last_p = 32'h0;

    always #5 clk = ~clk;

    sram22_param_model #(.WRITE_MODE(0), .OUT_REG(0), .CLEAR_VAL(CV)) u_base (
        .clk(clk), .rstb(rstb), .en(en), .we(we), .wmask(wmask), .addr(addr),
        .din(din), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b));

    sram22_param_model #(.WRITE_MODE(1), .OUT_REG(0), .CLEAR_VAL(CV)) u_wt (
        .clk(clk), .rstb(rstb), .en(en), .we(we), .wmask(wmask), .addr(addr),
        .din(din), .dout(dout_w), .dout_valid(dv_w), .busy(busy_w));

    sram22_param_model #(.WRITE_MODE(0), .OUT_REG(1), .CLEAR_VAL(CV)) u_pipe (
        .clk(clk), .rstb(rstb), .en(en), .we(we), .wmask(wmask), .addr(addr),
        .din(din), .dout(dout_p), .dout_valid(dv_p), .busy(busy_p));

    // Drive one accepted access and record what each instance must output.
    task automatic drive(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        logic [31:0] old_v, mrg;
        old_v = model_mem[a];
        mrg   = old_v;
        for (int k = 0; k < 4; k++) if (m[k]) mrg[k*8 +: 8] = d[k*8 +: 8];
        if (w) begin
            model_mem[a] = mrg;
            q_w.push_back(mrg);
        end else begin
            q_b.push_back(old_v);
            q_w.push_back(old_v);
            q_p.push_back(old_v);
        end
        en = 1'b1; we = w; addr = a; din = d; wmask = m;
    endtask

    task automatic idle();
        en = 1'b0; we = 1'b0;
    endtask

    // Drop outputs a scenario does not examine, remembering the final word.
    task automatic flush_q();
        if (q_b.size() > 0) last_b = q_b[$];
        if (q_w.size() > 0) last_w = q_w[$];
        if (q_p.size() > 0) last_p = q_p[$];
        q_b.delete(); q_w.delete(); q_p.delete();
    endtask

    task automatic fill_model();
        for (int i = 0; i < 256; i++) model_mem[i] = CV;
    endtask

    task automatic test_reset();
        rstb = 1'b0; idle();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy_b, busy_w, busy_p} !== 3'b111) begin
            n_bad++; $display("FAIL reset_busy: got %b want 111", {busy_b, busy_w, busy_p});
        end
        n_cmp++;
        if ({dv_b, dv_w, dv_p} !== 3'b000) begin
            n_bad++; $display("FAIL reset_valid: got %b want 000", {dv_b, dv_w, dv_p});
        end
        n_cmp++;
        if ({dout_b, dout_w, dout_p} !== 96'h0) begin
            n_bad++; $display("FAIL reset_dout: got %h %h %h want 0", dout_b, dout_w, dout_p);
        end
        last_b = 32'h0; last_w = 32'h0; last_p = 32'h0;
    endtask

    task automatic test_clear_engine();
        int n;
        logic [7:0] ra [3];
        logic [31:0] exp_v;
        ra[0] = 8'h00; ra[1] = 8'h7F; ra[2] = 8'hFF;
        @(negedge clk); rstb = 1'b1;
        n = 0;
        while (busy_b === 1'b1 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (n != 256) begin
            n_bad++; $display("FAIL clear_busy_cycles: got %0d want 256", n);
        end
        n_cmp++;
        if ({busy_w, busy_p} !== 2'b00) begin
            n_bad++; $display("FAIL clear_busy_others: got %b want 00", {busy_w, busy_p});
        end
        fill_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1'b0, ra[i], 32'h0, 4'h0);
            @(negedge clk); idle();
            n_cmp++;
            if (dv_b !== 1'b1 || q_b.size() == 0) begin
                n_bad++; $display("FAIL clear_rd_valid: got %b want 1 (addr %h)", dv_b, ra[i]);
            end else begin
                exp_v = q_b.pop_front(); last_b = exp_v;
                n_cmp++;
                if (dout_b !== exp_v) begin
                    n_bad++; $display("FAIL clear_rd_data: got %h want %h (addr %h)", dout_b, exp_v, ra[i]);
                end
            end
        end
        repeat (2) @(negedge clk);
        flush_q();
    endtask

    task automatic test_masked_write();
        logic [31:0] exp_v;
        @(negedge clk); drive(1'b1, 8'h10, 32'h11223344, 4'b1111);
        @(negedge clk);
        n_cmp++;
        if (dv_b !== 1'b0 || dout_b !== last_b) begin
            n_bad++; $display("FAIL mw_hold1: got %b/%h want 0/%h", dv_b, dout_b, last_b);
        end
        drive(1'b1, 8'h10, 32'hFFFFFFFF, 4'b0101);
        @(negedge clk);
        n_cmp++;
        if (dv_b !== 1'b0 || dout_b !== last_b) begin
            n_bad++; $display("FAIL mw_hold2: got %b/%h want 0/%h", dv_b, dout_b, last_b);
        end
        drive(1'b0, 8'h10, 32'h0, 4'h0);
        @(negedge clk); idle();
        n_cmp++;
        if (dv_b !== 1'b1 || q_b.size() == 0) begin
            n_bad++; $display("FAIL mw_rd_valid: got %b want 1", dv_b);
        end else begin
            exp_v = q_b.pop_front(); last_b = exp_v;
            n_cmp++;
            if (dout_b !== exp_v) begin
                n_bad++; $display("FAIL mw_rd_data: got %h want %h", dout_b, exp_v);
            end
        end
        repeat (2) @(negedge clk);
        flush_q();
    endtask

    task automatic test_write_through();
        logic [31:0] exp_v;
        @(negedge clk); drive(1'b1, 8'h03, 32'h0, 4'b1111);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 8'h03, 32'hDEADBEEF, 4'b0011); else idle();
            n_cmp++;
            if (dv_w !== 1'b1 || q_w.size() == 0) begin
                n_bad++; $display("FAIL wt_valid%0d: got %b want 1", c, dv_w);
            end else begin
                exp_v = q_w.pop_front(); last_w = exp_v;
                n_cmp++;
                if (dout_w !== exp_v) begin
                    n_bad++; $display("FAIL wt_data%0d: got %h want %h", c, dout_w, exp_v);
                end
            end
            n_cmp++;
            if (dv_b !== 1'b0 || dout_b !== last_b) begin
                n_bad++; $display("FAIL wm0_hold%0d: got %b/%h want 0/%h", c, dv_b, dout_b, last_b);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (dv_w !== 1'b0 || dout_w !== last_w) begin
            n_bad++; $display("FAIL wt_idle: got %b/%h want 0/%h", dv_w, dout_w, last_w);
        end
        flush_q();
    endtask

    task automatic test_pipeline();
        logic [31:0] exp_v;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); drive(1'b1, 8'(i), 32'(i), 4'hF);
        end
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
        flush_q();
        @(negedge clk); drive(1'b0, 8'h01, 32'h0, 4'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 2) drive(1'b0, 8'(c + 1), 32'h0, 4'h0); else idle();
            if (c == 1 || c == 5) begin
                n_cmp++;
                if (dv_p !== 1'b0 || dout_p !== last_p) begin
                    n_bad++; $display("FAIL pipe_idle_c%0d: got %b/%h want 0/%h", c, dv_p, dout_p, last_p);
                end
            end else begin
                n_cmp++;
                if (dv_p !== 1'b1 || q_p.size() == 0) begin
                    n_bad++; $display("FAIL pipe_valid_c%0d: got %b want 1", c, dv_p);
                end else begin
                    exp_v = q_p.pop_front(); last_p = exp_v;
                    n_cmp++;
                    if (dout_p !== exp_v) begin
                        n_bad++; $display("FAIL pipe_data_c%0d: got %h want %h", c, dout_p, exp_v);
                    end
                end
            end
        end
        repeat (2) @(negedge clk);
        flush_q();
    endtask

    task automatic test_enable_gating();
        logic [31:0] exp_v;
        @(negedge clk); en = 1'b0; we = 1'b0; addr = 8'h05;
        @(negedge clk);
        n_cmp++;
        if (dv_b !== 1'b0 || dout_b !== last_b) begin
            n_bad++; $display("FAIL en0_read: got %b/%h want 0/%h", dv_b, dout_b, last_b);
        end
        en = 1'b0; we = 1'b1; addr = 8'h09; din = 32'hCAFEF00D; wmask = 4'hF;
        @(negedge clk); drive(1'b0, 8'h09, 32'h0, 4'h0);
        @(negedge clk); idle();
        n_cmp++;
        if (dv_b !== 1'b1 || q_b.size() == 0) begin
            n_bad++; $display("FAIL en0_write_rd_valid: got %b want 1", dv_b);
        end else begin
            exp_v = q_b.pop_front(); last_b = exp_v;
            n_cmp++;
            if (dout_b !== exp_v) begin
                n_bad++; $display("FAIL en0_write_ignored: got %h want %h", dout_b, exp_v);
            end
        end
        repeat (2) @(negedge clk);
        flush_q();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dv_b === 1'b1) begin
                if (q_b.size() == 0) begin
                    n_bad++; $display("FAIL b2b_base_extra: got valid %h want none", dout_b);
                end else begin
                    exp_v = q_b.pop_front(); last_b = exp_v;
                    if (dout_b !== exp_v) begin
                        n_bad++; $display("FAIL b2b_base_data: got %h want %h (step %0d)", dout_b, exp_v, i);
                    end
                end
            end else if (dout_b !== last_b || dv_b !== 1'b0) begin
                n_bad++; $display("FAIL b2b_base_hold: got %b/%h want 0/%h (step %0d)", dv_b, dout_b, last_b, i);
            end
            n_cmp++;
            if (dv_w === 1'b1) begin
                if (q_w.size() == 0) begin
                    n_bad++; $display("FAIL b2b_wt_extra: got valid %h want none", dout_w);
                end else begin
                    exp_v = q_w.pop_front(); last_w = exp_v;
                    if (dout_w !== exp_v) begin
                        n_bad++; $display("FAIL b2b_wt_data: got %h want %h (step %0d)", dout_w, exp_v, i);
                    end
                end
            end else if (dout_w !== last_w || dv_w !== 1'b0) begin
                n_bad++; $display("FAIL b2b_wt_hold: got %b/%h want 0/%h (step %0d)", dv_w, dout_w, last_w, i);
            end
            n_cmp++;
            if (dv_p === 1'b1) begin
                if (q_p.size() == 0) begin
                    n_bad++; $display("FAIL b2b_pipe_extra: got valid %h want none", dout_p);
                end else begin
                    exp_v = q_p.pop_front(); last_p = exp_v;
                    if (dout_p !== exp_v) begin
                        n_bad++; $display("FAIL b2b_pipe_data: got %h want %h (step %0d)", dout_p, exp_v, i);
                    end
                end
            end else if (dout_p !== last_p || dv_p !== 1'b0) begin
                n_bad++; $display("FAIL b2b_pipe_hold: got %b/%h want 0/%h (step %0d)", dv_p, dout_p, last_p, i);
            end
            if (i < 40) drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom,
                              4'($urandom_range(0, 15)));
            else idle();
        end
        n_cmp++;
        if (q_b.size() + q_w.size() + q_p.size() != 0) begin
            n_bad++; $display("FAIL b2b_missing: got %0d/%0d/%0d pending want 0", q_b.size(), q_w.size(), q_p.size());
        end
        flush_q();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic [31:0] exp_v;
        @(negedge clk); rstb = 1'b0; idle();
        @(negedge clk); rstb = 1'b1;
        repeat (100) @(posedge clk);
        #1 rstb = 1'b0;
        #2;
        q_b.delete(); q_w.delete(); q_p.delete();
        last_b = 32'h0; last_w = 32'h0; last_p = 32'h0;
        n_cmp++;
        if ({busy_b, dv_b, dout_b} !== {1'b1, 1'b0, 32'h0}) begin
            n_bad++; $display("FAIL midclr_reset: got busy %b valid %b dout %h want 1 0 0", busy_b, dv_b, dout_b);
        end
        @(negedge clk); rstb = 1'b1;
        n = 0;
        while (busy_b === 1'b1 && n < 400) begin
            @(posedge clk); #1; n++;
            if (n == 100) begin
                en = 1'b1; we = 1'b1; addr = 8'h05; din = 32'h12345678; wmask = 4'hF;
            end
            if (n == 103) we = 1'b0;
            if (n == 106) begin
                n_cmp++;
                if ({dv_b, dv_w, dv_p} !== 3'b000 || {dout_b, dout_w, dout_p} !== 96'h0) begin
                    n_bad++; $display("FAIL busy_gating: got %b %h %h %h want 000 and 0", {dv_b, dv_w, dv_p}, dout_b, dout_w, dout_p);
                end
                idle();
            end
        end
        n_cmp++;
        if (n != 256) begin
            n_bad++; $display("FAIL midclr_busy_cycles: got %0d want 256", n);
        end
        fill_model();
        @(negedge clk); drive(1'b0, 8'd200, 32'h0, 4'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b0, 8'h05, 32'h0, 4'h0); else idle();
            n_cmp++;
            if (dv_b !== 1'b1 || q_b.size() == 0) begin
                n_bad++; $display("FAIL midclr_rd_valid%0d: got %b want 1", c, dv_b);
            end else begin
                exp_v = q_b.pop_front(); last_b = exp_v;
                n_cmp++;
                if (dout_b !== exp_v) begin
                    n_bad++; $display("FAIL midclr_rd_data%0d: got %h want %h", c, dout_b, exp_v);
                end
            end
        end
        repeat (2) @(negedge clk);
        flush_q();
    endtask

    initial begin
        test_reset();
        test_clear_engine();
        test_masked_write();
        test_write_through();
        test_pipeline();
        test_enable_gating();
        test_back_to_back();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end want end");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram22_param_model.md
Name: sram22_param_model

Overview:
Parametrised next-generation SRAM22 behavioural model for the sram-bist generator. It generalises data width, depth and write-mask granularity, and adds a chip enable, an optional output pipeline register and a selectable write-data output mode. It also adds a post-reset hardware clear engine, so BIST sees a deterministic array state instead of one set by a simulation-only initial block. BIST and the SRAM wrappers instantiate it in place of per-size fixed models.

Parameters:
DATA_WIDTH, 32, bits per word; must be a multiple of WMASK_WIDTH
ADDR_WIDTH, 8, address bits; RAM_DEPTH = 1 << ADDR_WIDTH
WMASK_WIDTH, 4, mask lanes; lane k covers bits [k*G +: G], G = DATA_WIDTH/WMASK_WIDTH
WRITE_MODE, 0, 0 = dout holds on write; 1 = write-through (dout shows merged new word)
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
CLEAR_VAL, 0, DATA_WIDTH-wide value written to every word by the clear engine

Ports:
clk  input  1  clock; all state updates on the rising edge
rstb  input  1  asynchronous active-low reset
en  input  1  chip enable; the access is ignored when 0
we  input  1  write enable (1 = write, 0 = read), qualified by en
wmask  input  WMASK_WIDTH  per-lane write enable
addr  input  ADDR_WIDTH  word address
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  read / write-through data
dout_valid  output  1  dout updated this cycle by an access
busy  output  1  clear engine active; accesses ignored

Behaviour:
- Reset (rstb=0, asynchronous):
  - dout=0, dout_valid=0, busy=1, clear counter=0, FSM=CLEAR.
  - Pipeline registers are cleared.
  - Array contents are undefined until the clear completes.
- FSM states CLEAR and READY:
  - CLEAR: on each cycle after rstb rises, write CLEAR_VAL to mem[cnt], then cnt++.
  - When cnt == RAM_DEPTH-1 is written, move to READY.
  - busy drops in the first READY cycle, exactly RAM_DEPTH cycles after the first clear edge.
- Reset asserted mid-clear: abort and restart from address 0 after release.
- While busy=1, en/we/addr/din are ignored: no array write, dout and dout_valid hold their reset state.
- Access is accepted in READY when en=1.
- Read (we=0), OUT_REG=0:
  - dout = mem[addr] at the next edge; dout_valid=1 for that one cycle.
- Read, OUT_REG=1: the same data and valid are delayed one more cycle (2-cycle latency).
- Write (we=1), per lane k: if wmask[k], the lane is updated from din; otherwise it keeps its old value.
  - wmask=0 with we=1 is a legal no-op write.
- WRITE_MODE=0 on a write: dout holds its previous value; dout_valid=0 in the slot the write would occupy.
- WRITE_MODE=1 on a write: dout = merged new word (old lanes where the mask is 0); dout_valid=1 with read latency.
- Never drive X on dout.
- en=0 or idle: dout holds its last value; dout_valid=0.
- Read after write to the same address on the next cycle returns the new data (no hazard).
- Back-to-back accesses are allowed every cycle; with OUT_REG=1 the pipeline is fully occupied and results stay in order.
- Address wrap does not apply: every addr value is in range.
- Parameter check: elaboration error if DATA_WIDTH % WMASK_WIDTH != 0.

Test Plan:
1. Clear engine (defaults, CLEAR_VAL=32'hA5A5A5A5):
   - Release rstb -> busy=1 for exactly 256 cycles, then 0.
   - Read of addr 0, 0x7F and 0xFF each returns 32'hA5A5A5A5 one cycle later, with dout_valid=1.
2. Masked write:
   - Write addr 0x10, din=32'h11223344, wmask=4'b1111, then write din=32'hFFFFFFFF, wmask=4'b0101.
   - Read addr 0x10 -> 32'h11FF33FF.
3. Write-through (WRITE_MODE=1):
   - Write addr 3 with 32'hDEADBEEF, wmask=4'b0011, over a cleared 0 word.
   - Next cycle: dout=32'h0000BEEF, dout_valid=1.
   - With WRITE_MODE=0, the same stimulus leaves dout unchanged and dout_valid=0.
4. OUT_REG=1 pipelining:
   - Reads of addr 1, 2, 3 on consecutive cycles (preloaded 1, 2, 3).
   - dout=1, 2, 3 appear on cycles 2, 3, 4 after the first request, with dout_valid high for 3 cycles.
5. Reset mid-clear:
   - Assert rstb at clear cycle 100, release.
   - busy stays high a full 256 cycles after release; addr 200 reads CLEAR_VAL.
6. Busy and enable gating:
   - A write to addr 5 issued while busy=1 has no effect; addr 5 later reads CLEAR_VAL.
   - A read with en=0 in READY leaves dout_valid=0 and dout unchanged.
